// File: rtl/uart_tx_fifo.sv
// UART transmit engine: byte FIFO feeding a start/data/parity/stop serialiser.
// Each frame latches its format and divisor when it is popped, so configuration
// changes only take effect from the next frame.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4,
  parameter int DIV_W      = 16
) (
  input  logic             sys_clk,
  input  logic             rst_b,
  input  logic [DIV_W-1:0] cfg_divisor,
  input  logic [1:0]       cfg_dls,
  input  logic             cfg_pen,
  input  logic             cfg_eps,
  input  logic             cfg_stop,
  input  logic             cfg_break,
  input  logic             fifo_clr,
  input  logic             wr_vld,
  input  logic [7:0]       wr_data,
  output logic             wr_rdy,
  input  logic [AW:0]      tx_thresh,
  output logic [AW:0]      tx_level,
  output logic             tx_thr_int,
  output logic             tx_ovf,
  output logic             tx_busy,
  output logic             tx_idle,
  output logic             s_out
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             full, push, pop, can_load, start_frame, bit_done, line;
  logic [7:0]       rd_data, load_mask;
  logic [DIV_W-1:0] load_div;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] baud_reg, baud_next, div_reg, div_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [1:0]       dls_reg, dls_next;
  logic             pen_reg, pen_next, par_reg, par_next, stop_reg, stop_next;
  logic             s_out_reg, s_out_next;

  // Full is judged before the edge, so a pop in the same cycle never frees room for a write.
  assign full     = (level_reg == (AW+1)'(FIFO_DEPTH));
  assign push     = wr_vld && !full && !fifo_clr;
  assign can_load = (level_reg != '0) && !fifo_clr;
  assign rd_data  = mem[rd_ptr_reg];

  assign load_div  = (cfg_divisor == '0) ? DIV_W'(1) : cfg_divisor;
  assign load_mask = 8'hFF >> (3'd3 - {1'b0, cfg_dls});
  assign bit_done  = (baud_reg == div_reg - 1'b1);

  // FIFO storage; no reset so it maps onto plain memory.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // FIFO pointers and occupancy; a flush wins over any concurrent push or pop.
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (fifo_clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      level_reg <= level_reg + 1'b1;
      else if (!push && pop) level_reg <= level_reg - 1'b1;
    end
  end

  // Serialiser next state: bit timing, frame sequencing and the registered pin value.
  always_comb begin
    state_next  = state_reg;
    baud_next   = bit_done ? '0 : baud_reg + 1'b1;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    div_next    = div_reg;
    dls_next    = dls_reg;
    pen_next    = pen_reg;
    par_next    = par_reg;
    stop_next   = stop_reg;
    pop         = 1'b0;
    start_frame = 1'b0;
    line        = 1'b1;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (can_load) start_frame = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == {1'b0, dls_reg} + 3'd4) begin
            state_next = pen_reg ? PARITY : STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          bit_next   = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_reg == {2'b00, stop_reg}) begin
            if (can_load) start_frame = 1'b1;
            else          state_next  = IDLE;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Popping a byte latches it together with the whole frame format.
    if (start_frame) begin
      pop        = 1'b1;
      state_next = START;
      baud_next  = '0;
      bit_next   = '0;
      shift_next = rd_data;
      div_next   = load_div;
      dls_next   = cfg_dls;
      pen_next   = cfg_pen;
      par_next   = cfg_eps ? ^(rd_data & load_mask) : ~^(rd_data & load_mask);
      stop_next  = cfg_stop;
    end

    case (state_next)
      START:   line = 1'b0;
      DATA:    line = shift_next[0];
      PARITY:  line = par_next;
      default: line = 1'b1;
    endcase
    s_out_next = cfg_break ? 1'b0 : line;
  end

  // Serialiser state registers; reset drives the line to its idle-high level at once.
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      div_reg   <= '0;
      dls_reg   <= '0;
      pen_reg   <= 1'b0;
      par_reg   <= 1'b0;
      stop_reg  <= 1'b0;
      s_out_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      div_reg   <= div_next;
      dls_reg   <= dls_next;
      pen_reg   <= pen_next;
      par_reg   <= par_next;
      stop_reg  <= stop_next;
      s_out_reg <= s_out_next;
    end
  end

  assign wr_rdy     = !full;
  assign tx_level   = level_reg;
  assign tx_thr_int = (level_reg <= tx_thresh);
  assign tx_ovf     = wr_vld && full;
  assign tx_busy    = (state_reg != IDLE);
  assign tx_idle    = (level_reg == '0) && (state_reg == IDLE);
  assign s_out      = s_out_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected line waveform built from frame rules into a bit queue.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DIV_W = 16;

  logic             sys_clk = 1'b0;
  logic             rst_b;
  logic [DIV_W-1:0] cfg_divisor;
  logic [1:0]       cfg_dls;
  logic             cfg_pen, cfg_eps, cfg_stop, cfg_break, fifo_clr, wr_vld;
  logic [7:0]       wr_data;
  logic             wr_rdy, tx_thr_int, tx_ovf, tx_busy, tx_idle, s_out;
  logic [AW:0]      tx_thresh, tx_level;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit mon_en  = 1'b0;
  bit started = 1'b0;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W)) dut (
    .sys_clk(sys_clk), .rst_b(rst_b), .cfg_divisor(cfg_divisor), .cfg_dls(cfg_dls),
    .cfg_pen(cfg_pen), .cfg_eps(cfg_eps), .cfg_stop(cfg_stop), .cfg_break(cfg_break),
    .fifo_clr(fifo_clr), .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .tx_thresh(tx_thresh), .tx_level(tx_level), .tx_thr_int(tx_thr_int), .tx_ovf(tx_ovf),
    .tx_busy(tx_busy), .tx_idle(tx_idle), .s_out(s_out)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, dls+5 data bits LSB first, optional parity, 1/2 stops, each bit len cycles.
  function automatic void add_frame(input logic [7:0] d, input logic [1:0] dls, input logic pen,
                                    input logic eps, input logic stp, input logic [15:0] div);
    int n    = 5 + int'(dls);
    int len  = (div == 0) ? 1 : int'(div);
    int ones = 0;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) bits.push_back(eps ? (ones % 2 == 1) : (ones % 2 == 0));
    bits.push_back(1'b1);
    if (stp) bits.push_back(1'b1);
    foreach (bits[i]) repeat (len) exp_q.push_back(bits[i]);
  endfunction

  // One-cycle write; the model only learns bytes the DUT should accept.
  task automatic write_frame(input logic [7:0] d);
    if (wr_rdy && !fifo_clr)
      add_frame(d, cfg_dls, cfg_pen, cfg_eps, cfg_stop, cfg_divisor);
    wr_vld  = 1'b1;
    wr_data = d;
    tick();
    wr_vld  = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !tx_idle) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size() == 0 && tx_idle), 32'd1);
  endtask

  task automatic wait_level(input string tag, input int target, input int budget);
    int n = 0;
    while (tx_level != target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_level), 32'(target));
  endtask

  // Line monitor: once a start bit appears, every cycle must follow the expected waveform.
  always begin
    @(posedge sys_clk);
    #1;
    if (mon_en) begin
      if (!started && exp_q.size() != 0 && s_out === 1'b0) started = 1'b1;
      if (started) begin
        check("serial_bit", 32'(s_out), 32'(exp_q.pop_front()));
        if (exp_q.size() == 0) started = 1'b0;
      end else if (exp_q.size() == 0) begin
        check("line_idle", 32'(s_out), 32'd1);
      end
    end
  end

  initial begin
    int n, cnt;
    logic [7:0] b;
    rst_b = 1'b0; cfg_divisor = 16'd4; cfg_dls = 2'd3; cfg_pen = 1'b0; cfg_eps = 1'b0;
    cfg_stop = 1'b0; cfg_break = 1'b0; fifo_clr = 1'b0; wr_vld = 1'b0; wr_data = 8'h00;
    tx_thresh = '0;
    repeat (3) tick();
    check("rst_s_out", 32'(s_out), 32'd1);
    check("rst_level", 32'(tx_level), 32'd0);
    check("rst_wr_rdy", 32'(wr_rdy), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_idle", 32'(tx_idle), 32'd1);
    check("rst_ovf", 32'(tx_ovf), 32'd0);
    check("rst_thr_int", 32'(tx_thr_int), 32'd1);
    rst_b = 1'b1;
    tick();
    mon_en = 1'b1;

    // 8N1, divisor 4, 0xA5; start bit appears on the edge after acceptance.
    write_frame(8'hA5);
    check("t1_level", 32'(tx_level), 32'd1);
    check("t1_pre_start", 32'(s_out), 32'd1);
    tick();
    check("t1_start_edge", 32'(s_out), 32'd0);
    check("t1_busy", 32'(tx_busy), 32'd1);
    wait_drain("t1", 100);

    // 5 data bits, even parity, 2 stop bits.
    cfg_dls = 2'd0; cfg_pen = 1'b1; cfg_eps = 1'b1; cfg_stop = 1'b1; cfg_divisor = 16'd2;
    write_frame(8'h07);
    wait_drain("t2", 100);

    // Random formats; config is scrambled mid-frame and must not disturb the frame in flight.
    for (int i = 0; i < 8; i++) begin
      cfg_dls = 2'($urandom_range(0, 3)); cfg_pen = 1'($urandom_range(0, 1));
      cfg_eps = 1'($urandom_range(0, 1)); cfg_stop = 1'($urandom_range(0, 1));
      cfg_divisor = 16'($urandom_range(0, 3));
      write_frame(8'($urandom_range(0, 255)));
      n = 0;
      while (s_out !== 1'b0 && n < 10) begin tick(); n++; end
      check("rand_start", 32'(s_out), 32'd0);
      cfg_dls = 2'($urandom_range(0, 3)); cfg_pen = 1'($urandom_range(0, 1));
      cfg_eps = 1'($urandom_range(0, 1)); cfg_stop = 1'($urandom_range(0, 1));
      cfg_divisor = 16'($urandom_range(0, 7));
      wait_drain("rand", 200);
    end

    // Back-to-back frames at divisor 1 with threshold interrupt tracking the level.
    cfg_dls = 2'd3; cfg_pen = 1'b0; cfg_stop = 1'b0; cfg_divisor = 16'd1; tx_thresh = 5'd2;
    for (int i = 0; i < 4; i++) write_frame(8'($urandom_range(0, 255)));
    check("t3_level3", 32'(tx_level), 32'd3);
    check("t3_thr_low", 32'(tx_thr_int), 32'd0);
    wait_level("t3_level2", 2, 20);
    check("t3_thr_high", 32'(tx_thr_int), 32'd1);
    wait_level("t3_level1", 1, 20);
    wait_level("t3_level0", 0, 20);
    wait_drain("t3", 60);

    // Overflow: 17 accepted writes fill the FIFO behind the frame in flight.
    cfg_divisor = 16'd8;
    for (int i = 0; i < 17; i++) write_frame(8'($urandom_range(0, 255)));
    check("t4_level_full", 32'(tx_level), 32'd16);
    check("t4_wr_rdy", 32'(wr_rdy), 32'd0);
    wr_vld = 1'b1; wr_data = 8'h3C;
    #1;
    check("t4_ovf_pulse", 32'(tx_ovf), 32'd1);
    tick();
    wr_vld = 1'b0;
    #1;
    check("t4_ovf_clear", 32'(tx_ovf), 32'd0);
    check("t4_level_kept", 32'(tx_level), 32'd16);
    wait_drain("t4", 1600);

    // Flush mid-frame with a concurrent write; the current frame still finishes.
    mon_en = 1'b0;
    cfg_divisor = 16'd4;
    for (int i = 0; i < 4; i++) write_frame(8'h00);
    exp_q.delete();
    started = 1'b0;
    wait_level("t5_level2", 2, 60);
    check("t5_thr", 32'(tx_thr_int), 32'd1);
    repeat (5) tick();
    fifo_clr = 1'b1; wr_vld = 1'b1; wr_data = 8'h55;
    tick();
    fifo_clr = 1'b0; wr_vld = 1'b0;
    check("t5_clr_level", 32'(tx_level), 32'd0);
    check("t5_busy_after_clr", 32'(tx_busy), 32'd1);
    n = 0;
    while (!tx_idle && n < 100) begin tick(); n++; end
    check("t5_idle", 32'(tx_idle), 32'd1);
    check("t5_frame_ran", 32'(n > 20), 32'd1);
    cnt = 0;
    repeat (60) begin tick(); if (s_out === 1'b0) cnt++; end
    check("t5_no_more_frames", 32'(cnt), 32'd0);

    // Break: line held low while the frame is still clocked out and popped.
    cfg_break = 1'b1; cfg_divisor = 16'd2;
    tick();
    write_frame(8'hFF);
    exp_q.delete();
    cnt = 0;
    repeat (25) begin tick(); if (s_out !== 1'b0) cnt++; end
    check("brk_line_low", 32'(cnt), 32'd0);
    check("brk_popped", 32'(tx_idle), 32'd1);
    cfg_break = 1'b0;
    tick();
    check("brk_release", 32'(s_out), 32'd1);

    // Asynchronous reset during DATA.
    cfg_divisor = 16'd4;
    for (int i = 0; i < 3; i++) write_frame(8'h00);
    exp_q.delete();
    repeat (4) tick();
    check("t6_in_data", 32'(s_out), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    check("t6_async_s_out", 32'(s_out), 32'd1);
    check("t6_level_lost", 32'(tx_level), 32'd0);
    check("t6_busy", 32'(tx_busy), 32'd0);
    tick();
    rst_b = 1'b1;
    cnt = 0;
    repeat (50) begin tick(); if (s_out === 1'b0) cnt++; end
    check("t6_silent", 32'(cnt), 32'd0);
    check("t6_idle", 32'(tx_idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
